// File: rtl/slice_serial_adder.sv
// slice_serial_adder
// Multi-cycle adder: WIDTH-bit operands plus carry-in are summed SLICE bits
// per clock, LSB slice first, with a registered carry between slices.
// A start/busy/done handshake connects it to a controlling FSM.
//
// Optional build macro:
//   SLICE_ADDER_SUB_EN - adds a 'sub' input; sub=1 computes a-b (two's
//                        complement: ~b with the carry register forced to 1).
module slice_serial_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SLICE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    // Operand registers shift right by one slice per cycle, so the slice
    // being added is always their low SLICE bits.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;

    logic [WIDTH-1:0] b_eff;
    logic             carry_init;
    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE:0]   slice_sum;
    logic             msb_carry_in;
    logic [31:0]      slice_base;
    logic [WIDTH-1:0] slice_placed;

    // Condition the second operand and initial carry at the start edge
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        b_eff      = b;
        carry_init = cin;
`ifdef SLICE_ADDER_SUB_EN
        if (sub) begin
            b_eff      = ~b;
            carry_init = 1'b1;
        end
`endif
    end

    // One ripple slice: low operand bits plus the registered carry
    always_comb begin
        a_slice      = a_q[SLICE-1:0];
        b_slice      = b_q[SLICE-1:0];
        slice_sum    = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry_q};
        // Carry into the top bit of this slice; on the last slice this is
        // the carry into bit WIDTH-1.
        msb_carry_in = a_slice[SLICE-1] ^ b_slice[SLICE-1] ^ slice_sum[SLICE-1];
        slice_base   = 32'(idx) * 32'(SLICE);
        slice_placed = WIDTH'(slice_sum[SLICE-1:0]) << slice_base;
    end

    // Control FSM and result registers
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        state    <= RUN;
                        idx      <= '0;
                        a_q      <= a;
                        b_q      <= b_eff;
                        carry_q  <= carry_init;
                        busy     <= 1'b1;
                        sum      <= '0;
                        cout     <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                RUN: begin
                    // sum was cleared at start, so OR-ing places the slice
                    sum     <= sum | slice_placed;
                    carry_q <= slice_sum[SLICE];
                    a_q     <= a_q >> SLICE;
                    b_q     <= b_q >> SLICE;
                    if (idx == LAST_IDX) begin
                        cout     <= slice_sum[SLICE];
                        overflow <= msb_carry_in ^ slice_sum[SLICE];
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slice_serial_adder.sv
// Testbench for slice_serial_adder (WIDTH=32, SLICE=4).
// Expected results are pushed to a scoreboard queue at each accepted start
// and popped when done pulses.
module tb_slice_serial_adder;

    localparam int WIDTH = 32;
    localparam int SLICE = 4;
    localparam int N     = WIDTH / SLICE;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SLICE_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    slice_serial_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SLICE_ADDER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width addition, signed overflow from operand/result signs
    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic c, input logic s);
        logic [WIDTH-1:0] bb;
        logic             ci;
        logic [WIDTH:0]   r;
        exp_t             e;
        bb    = s ? ~bv : bv;
        ci    = s ? 1'b1 : c;
        r     = {1'b0, av} + {1'b0, bb} + (WIDTH+1)'(ci);
        e.sum  = r[WIDTH-1:0];
        e.cout = r[WIDTH];
        e.ovf  = (av[WIDTH-1] == bb[WIDTH-1]) && (r[WIDTH-1] != av[WIDTH-1]);
        return e;
    endfunction

    // Present one start pulse across one rising edge; scramble operands afterwards
    task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic c, input logic s);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = c;
`ifdef SLICE_ADDER_SUB_EN
        sub   = s;
`endif
        sb.push_back(model(av, bv, c, s));
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        cin   = 1'b1;
`ifdef SLICE_ADDER_SUB_EN
        sub   = 1'b1;
`endif
    endtask

    // Bounded wait for done; counts rising edges after the start edge
    task automatic wait_done(output int edges, output bit seen, output bit busy_ok);
        edges   = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && edges < 4 * N) begin
            @(negedge clk);
            edges++;
            if (done) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef SLICE_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, cout, overflow, sum} !== '0) begin
            failures++;
            $display("FAIL reset_hold got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0",
                     busy, done, sum, cout, overflow);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, cout, overflow, sum} !== '0) begin
                failures++;
                $display("FAIL idle_cycle_%0d got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0",
                         i, busy, done, sum, cout, overflow);
            end
        end
    endtask

    // Run one operation from an idle cycle and score it
    task automatic run_op(input string name, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic c, input logic s);
        int   edges;
        bit   seen;
        bit   busy_ok;
        exp_t e;
        launch(av, bv, c, s);
        checks++;
        if (busy !== 1'b1 || sum !== '0) begin
            failures++;
            $display("FAIL %s_after_start got busy=%b sum=%h exp busy=1 sum=0", name, busy, sum);
        end
        wait_done(edges, seen, busy_ok);
        e = sb.pop_front();
        checks++;
        if (!seen || edges != N) begin
            failures++;
            $display("FAIL %s_latency got seen=%b edges=%0d exp edges=%0d", name, seen, edges, N);
        end
        checks++;
        if (!busy_ok || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy got busy_ok=%b busy_at_done=%b exp 1/0", name, busy_ok, busy);
        end
        checks++;
        if ({sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
            failures++;
            $display("FAIL %s_result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                     name, sum, cout, overflow, e.sum, e.cout, e.ovf);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || {sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
            failures++;
            $display("FAIL %s_hold got done=%b sum=%h cout=%b ovf=%b exp done=0 sum=%h",
                     name, done, sum, cout, overflow, e.sum);
        end
    endtask

    task automatic test_basic;
        run_op("add_5_3", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
    endtask

    task automatic test_wrap;
        run_op("wrap_ones_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run_op("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("mixed", 32'h89AB_CDEF, 32'h7654_3210, 1'b1, 1'b0);
    endtask

    // start held during RUN must not disturb the operation; a start in the
    // DONE cycle must launch back-to-back
    task automatic test_back_to_back;
        int   edges;
        bit   seen;
        bit   busy_ok;
        exp_t e;
        launch(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0);
        start = 1'b1;
        a     = 32'hDEAD_BEEF;
        b     = 32'hFFFF_FFFF;
        cin   = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(edges, seen, busy_ok);
        e = sb.pop_front();
        checks++;
        if (!seen || edges + 3 != N) begin
            failures++;
            $display("FAIL ignored_start_latency got seen=%b edges=%0d exp edges=%0d",
                     seen, edges + 3, N);
        end
        checks++;
        if ({sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
            failures++;
            $display("FAIL ignored_start_result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                     sum, cout, overflow, e.sum, e.cout, e.ovf);
        end
        // Now in the DONE cycle: start the second operation immediately
        launch(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || sum !== '0) begin
            failures++;
            $display("FAIL b2b_start got done=%b busy=%b sum=%h exp done=0 busy=1 sum=0",
                     done, busy, sum);
        end
        wait_done(edges, seen, busy_ok);
        e = sb.pop_front();
        checks++;
        if (!seen || edges != N || !busy_ok) begin
            failures++;
            $display("FAIL b2b_latency got seen=%b edges=%0d busy_ok=%b exp edges=%0d",
                     seen, edges, busy_ok, N);
        end
        checks++;
        if ({sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
            failures++;
            $display("FAIL b2b_result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                     sum, cout, overflow, e.sum, e.cout, e.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        bit saw_done;
        launch(32'h1357_9BDF, 32'h2468_ACE0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_front());
        checks++;
        if ({busy, done, cout, overflow, sum} !== '0) begin
            failures++;
            $display("FAIL mid_reset_clear got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0",
                     busy, done, sum, cout, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL mid_reset_no_done got activity=1 exp 0");
        end
        run_op("after_reset", 32'hCAFE_F00D, 32'h3501_0FF3, 1'b0, 1'b0);
    endtask

`ifdef SLICE_ADDER_SUB_EN
    task automatic test_sub;
        run_op("sub_5_7", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        run_op("sub_off", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_reset_mid_op();
`ifdef SLICE_ADDER_SUB_EN
        test_sub();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
